// File: rtl/pingpong_pkg.sv
// Shared constants and helpers for the ping-pong buffer controller.
// Holds the default bank geometry and the bank-count constant.
package pingpong_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_BANKS  = 2;

  typedef logic [NUM_BANKS-1:0] bank_mask_t;

  function automatic logic [1:0] popcount2(input bank_mask_t v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

  function automatic bank_mask_t bankOneHot(input logic sel);
    return sel ? bank_mask_t'(2'b10) : bank_mask_t'(2'b01);
  endfunction

endpackage

// File: rtl/pingpong_ptr.sv
// Word pointer plus bank select for one side of the ping-pong buffer.
// Flags the wrap cycle combinationally and pulses o_done one cycle later.
module pingpong_ptr
  import pingpong_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_sel,
  output logic              o_wrap,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_ptr;
  logic              r_sel;
  logic              r_done;
  logic              w_wrap;

  assign w_wrap = i_adv & (r_ptr == {ADDR_W{1'b1}});

  // The pointer rolls over to zero by natural overflow on the last word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr  <= '0;
      r_sel  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_wrap;
      if (i_adv) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_wrap) begin
        r_sel <= ~r_sel;
      end
    end
  end

  assign o_ptr  = r_ptr;
  assign o_sel  = r_sel;
  assign o_wrap = w_wrap;
  assign o_done = r_done;

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller: producer fills one bank while the consumer
// drains the other; banks swap when a side finishes its frame.
module pingpong_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        bank_we,
  output logic [1:0]        bank_re,
  output logic [ADDR_W-1:0] bank_waddr,
  output logic [ADDR_W-1:0] bank_raddr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank0_rdata,
  input  logic [DATA_W-1:0] bank1_rdata,
  output logic              wr_bank_done,
  output logic              rd_bank_done,
  output logic [1:0]        full_cnt
);

  bank_mask_t        r_bankFull;
  logic [1:0]        r_fullCnt;
  logic              r_rdValid;
  logic              r_rdSel;

  logic              w_wsel;
  logic              w_rsel;
  logic [ADDR_W-1:0] w_wptr;
  logic [ADDR_W-1:0] w_rptr;
  logic              w_wrWrap;
  logic              w_rdWrap;
  logic              w_wrAcc;
  logic              w_rdAcc;
  bank_mask_t        w_fullNext;

  // Qualifying with resetn keeps both enables low while reset is held.
  assign w_wrAcc = resetn & wr_valid & ~r_bankFull[w_wsel];
  assign w_rdAcc = resetn & rd_req & r_bankFull[w_rsel];

  pingpong_ptr #(.ADDR_W(ADDR_W)) u_wrPtr (
    .clk    (clk),
    .resetn (resetn),
    .i_adv  (w_wrAcc),
    .o_ptr  (w_wptr),
    .o_sel  (w_wsel),
    .o_wrap (w_wrWrap),
    .o_done (wr_bank_done)
  );

  pingpong_ptr #(.ADDR_W(ADDR_W)) u_rdPtr (
    .clk    (clk),
    .resetn (resetn),
    .i_adv  (w_rdAcc),
    .o_ptr  (w_rptr),
    .o_sel  (w_rsel),
    .o_wrap (w_rdWrap),
    .o_done (rd_bank_done)
  );

  // A filling bank is never full and a draining bank always is, so the set
  // and clear masks never hit the same bank and can apply on one edge.
  always_comb begin
    w_fullNext = r_bankFull;
    if (w_wrWrap) w_fullNext = w_fullNext | bankOneHot(w_wsel);
    if (w_rdWrap) w_fullNext = w_fullNext & ~bankOneHot(w_rsel);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bankFull <= '0;
      r_fullCnt  <= 2'd0;
      r_rdValid  <= 1'b0;
      r_rdSel    <= 1'b0;
    end else begin
      r_bankFull <= w_fullNext;
      r_fullCnt  <= popcount2(w_fullNext);
      r_rdValid  <= w_rdAcc;
      r_rdSel    <= w_rsel;
    end
  end

  assign wr_ready   = ~r_bankFull[w_wsel];
  assign bank_we    = w_wrAcc ? bankOneHot(w_wsel) : 2'b00;
  assign bank_re    = w_rdAcc ? bankOneHot(w_rsel) : 2'b00;
  assign bank_waddr = w_wptr;
  assign bank_raddr = w_rptr;
  assign bank_wdata = wr_data;
  assign rd_valid   = r_rdValid;
  assign rd_data    = r_rdSel ? bank1_rdata : bank0_rdata;
  assign full_cnt   = r_fullCnt;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Scoreboard bench for pingpong_buf_ctrl: a frame-counting reference model
// predicts handshakes and a monitor checks returned words in order.
module tb_pingpong_buf_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          resetn;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0]    bank_we;
  logic [1:0]    bank_re;
  logic [AW-1:0] bank_waddr;
  logic [AW-1:0] bank_raddr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank0_rdata;
  logic [DW-1:0] bank1_rdata;
  logic          wr_bank_done;
  logic          rd_bank_done;
  logic [1:0]    full_cnt;

  pingpong_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_req       (rd_req),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .bank_we      (bank_we),
    .bank_re      (bank_re),
    .bank_waddr   (bank_waddr),
    .bank_raddr   (bank_raddr),
    .bank_wdata   (bank_wdata),
    .bank0_rdata  (bank0_rdata),
    .bank1_rdata  (bank1_rdata),
    .wr_bank_done (wr_bank_done),
    .rd_bank_done (rd_bank_done),
    .full_cnt     (full_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two synchronous RAM banks with one-cycle read latency.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (bank_we[0]) mem0[bank_waddr] <= bank_wdata;
    if (bank_we[1]) mem1[bank_waddr] <= bank_wdata;
    if (bank_re[0]) bank0_rdata <= mem0[bank_raddr];
    if (bank_re[1]) bank1_rdata <= mem1[bank_raddr];
  end

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: words accepted in and out since reset, plus the words in flight.
  int            wCount = 0;
  int            rCount = 0;
  logic [DW-1:0] nextWord = 8'd0;
  logic [DW-1:0] dataQ [$];
  bit            expRdValid = 1'b0;
  bit            expWrDone = 1'b0;
  bit            expRdDone = 1'b0;
  int            expFullCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus (starting just after a falling edge) and
  // checks the combinational handshake against the frame-count model.
  task automatic applyStimulus(input bit wv, input bit rq);
    int fw, fr;
    bit wAcc, rAcc;
    logic [1:0] expWe, expRe;
    wr_valid = wv;
    rd_req   = rq;
    wr_data  = nextWord;
    #1;
    fw = wCount / DEPTH;
    fr = rCount / DEPTH;
    wAcc = wv && ((fw - fr) < 2);
    rAcc = rq && (fw > fr);
    expWe = wAcc ? ((fw % 2) ? 2'b10 : 2'b01) : 2'b00;
    expRe = rAcc ? ((fr % 2) ? 2'b10 : 2'b01) : 2'b00;
    checkOutput("wr_ready", 32'(wr_ready), 32'((fw - fr) < 2));
    checkOutput("bank_we", 32'(bank_we), 32'(expWe));
    checkOutput("bank_re", 32'(bank_re), 32'(expRe));
    checkOutput("we_re_overlap", 32'(bank_we & bank_re), 32'd0);
    if (wAcc) begin
      checkOutput("bank_waddr", 32'(bank_waddr), 32'(wCount % DEPTH));
      checkOutput("bank_wdata", 32'(bank_wdata), 32'(nextWord));
    end
    if (rAcc) checkOutput("bank_raddr", 32'(bank_raddr), 32'(rCount % DEPTH));
    expWrDone  = wAcc && ((wCount % DEPTH) == DEPTH - 1);
    expRdDone  = rAcc && ((rCount % DEPTH) == DEPTH - 1);
    expRdValid = rAcc;
    if (wAcc) begin
      dataQ.push_back(nextWord);
      wCount++;
      nextWord++;
    end
    if (rAcc) rCount++;
    expFullCnt = wCount / DEPTH - rCount / DEPTH;
    @(negedge clk);
  endtask

  task automatic clearModel(input logic [DW-1:0] firstWord);
    wCount = 0;
    rCount = 0;
    dataQ.delete();
    nextWord = firstWord;
    expRdValid = 1'b0;
    expWrDone = 1'b0;
    expRdDone = 1'b0;
    expFullCnt = 0;
  endtask

  // Asserts reset mid-cycle with both requests high and checks the
  // asynchronous clearing before the next clock edge.
  task automatic pulseReset(input logic [DW-1:0] firstWord);
    #3;
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    resetn   = 1'b0;
    #1;
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_full_cnt", 32'(full_cnt), 32'd0);
    checkOutput("rst_bank_we", 32'(bank_we), 32'd0);
    checkOutput("rst_bank_re", 32'(bank_re), 32'd0);
    checkOutput("rst_wr_done", 32'(wr_bank_done), 32'd0);
    checkOutput("rst_rd_done", 32'(rd_bank_done), 32'd0);
    clearModel(firstWord);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: compares registered outputs after every rising edge.
  always begin
    @(posedge clk);
    #2;
    if (resetn) begin
      checkOutput("rd_valid", 32'(rd_valid), 32'(expRdValid));
      checkOutput("wr_bank_done", 32'(wr_bank_done), 32'(expWrDone));
      checkOutput("rd_bank_done", 32'(rd_bank_done), 32'(expRdDone));
      checkOutput("full_cnt", 32'(full_cnt), 32'(expFullCnt));
      if (rd_valid) begin
        if (dataQ.size() == 0) begin
          checkOutput("rd_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          checkOutput("rd_data", 32'(rd_data), 32'(dataQ.pop_front()));
        end
      end
    end
  end

  initial begin
    int cycles;
    resetn   = 1'b0;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    wr_data  = '0;
    @(negedge clk);
    pulseReset(8'd0);

    // Fill both banks with no reads, then stall the 65th word.
    for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("filled_wcount", 32'(wCount), 32'(2 * DEPTH));

    // Drain with rd_req held high while the producer keeps offering words.
    for (int i = 0; i < 2 * DEPTH + 4; i++) applyStimulus(1'b1, 1'b1);
    cycles = 0;
    while (rCount < wCount - (wCount % DEPTH) && cycles < 200) begin
      applyStimulus(1'b0, 1'b1);
      cycles++;
    end
    checkOutput("drain_bound", 32'(cycles < 200), 32'd1);

    // Random streaming of 256 incrementing words after a fresh reset.
    pulseReset(8'd0);
    cycles = 0;
    while ((wCount < 256 || rCount < 256) && cycles < 5000) begin
      applyStimulus((wCount < 256) && ($urandom_range(0, 99) < 70),
                    $urandom_range(0, 99) < 60);
      cycles++;
    end
    checkOutput("stream_bound", 32'(cycles < 5000), 32'd1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("stream_q_empty", 32'(dataQ.size()), 32'd0);

    // Reset after a partial frame; nothing may be read until 32 new writes.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
    pulseReset(8'h50);
    cycles = 0;
    while (rCount < DEPTH && cycles < 1000) begin
      applyStimulus((wCount < DEPTH) && ($urandom_range(0, 99) < 80), 1'b1);
      cycles++;
    end
    checkOutput("post_reset_bound", 32'(cycles < 1000), 32'd1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_q_empty", 32'(dataQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pingpong_buf_ctrl.md
PINGPONG_BUF_CTRL -- requirements
Module: pingpong_buf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, bank address width; DEPTH = 2**ADDR_W words per bank.
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_valid  input  1  producer word valid.
REQ-006 SHALL have port wr_data  input  DATA_W  producer word.
REQ-007 SHALL have port wr_ready  output  1  controller accepts word this cycle.
REQ-008 SHALL have port rd_req  input  1  consumer requests next word.
REQ-009 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-010 SHALL have port rd_data  output  DATA_W  word returned to consumer.
REQ-011 SHALL have port bank_we  output  2  per-bank write enable, one-hot or zero.
REQ-012 SHALL have port bank_re  output  2  per-bank read enable, one-hot or zero.
REQ-013 SHALL have port bank_waddr  output  ADDR_W  shared write address.
REQ-014 SHALL have port bank_raddr  output  ADDR_W  shared read address.
REQ-015 SHALL have port bank_wdata  output  DATA_W  shared write data (wr_data passed through).
REQ-016 SHALL have port bank0_rdata  input  DATA_W  bank 0 read data, one-cycle synchronous RAM latency.
REQ-017 SHALL have port bank1_rdata  input  DATA_W  bank 1 read data, one-cycle synchronous RAM latency.
REQ-018 SHALL have port wr_bank_done  output  1  one-cycle pulse: write bank filled.
REQ-019 SHALL have port rd_bank_done  output  1  one-cycle pulse: read bank drained.
REQ-020 SHALL have port full_cnt  output  2  number of full banks, 0..2.

Function
REQ-021 SHALL keep state: wsel, rsel (1 bit each), wptr, rptr (ADDR_W each), bank_full[1:0].
REQ-022 SHALL drive wr_ready = !bank_full[wsel], combinational.
REQ-023 On wr_valid & wr_ready: bank_we[wsel]=1, bank_waddr=wptr, same cycle; wptr increments next edge.
REQ-024 On write accept with wptr==DEPTH-1: wptr->0, bank_full[wsel]->1, wsel toggles, wr_bank_done pulses next cycle.
REQ-025 SHALL accept a read when rd_req & bank_full[rsel]; then bank_re[rsel]=1, bank_raddr=rptr, same cycle; rptr increments next edge.
REQ-026 rd_req while !bank_full[rsel] SHALL be ignored (no bank_re, no rd_valid); consumer must re-request.
REQ-027 rd_valid SHALL assert exactly one cycle after each accepted read; rd_data = bank1_rdata if registered rsel of that read is 1, else bank0_rdata.
REQ-028 On read accept with rptr==DEPTH-1: rptr->0, bank_full[rsel]->0, rsel toggles, rd_bank_done pulses next cycle.
REQ-029 Write to a full bank and read from a non-full bank SHALL be impossible; simultaneous fill completion and drain completion SHALL both take effect in the same edge.
REQ-030 Word order out SHALL equal word order in; banks alternate 0,1,0,... on both sides.
REQ-031 full_cnt SHALL equal popcount(bank_full), registered.
REQ-032 Sustained throughput SHALL be one write and one read per cycle when neither side stalls.

Reset
REQ-033 resetn low SHALL asynchronously clear wsel, rsel, wptr, rptr, bank_full, rd_valid, wr_bank_done, rd_bank_done, full_cnt; bank_we/bank_re SHALL be 0 while reset is asserted.
REQ-034 Reset mid-frame SHALL discard partial and full frames; RAM contents are not cleared and never read before refilled.

Structure
REQ-035 Package pingpong_pkg SHALL hold ADDR_W/DATA_W defaults and the NUM_BANKS=2 constant.
REQ-036 One sub-module pingpong_ptr (pointer, bank select, wrap pulse) SHALL be instantiated twice, for the write side and the read side.

Verification (DEPTH=32, DATA_W=8)
REQ-037 Reset -> wr_ready=1, rd_valid=0, full_cnt=0, bank_we=bank_re=0.
REQ-038 Write 0..31 back-to-back, no reads -> bank_we=01 throughout, wr_bank_done one cycle after 32nd accept, full_cnt=1, wr_ready stays 1.
REQ-039 Write 64 words, no reads -> full_cnt=2, wr_ready=0; 65th word held until first read frame drains.
REQ-040 After REQ-039, rd_req held high -> rd_data 0..63 in order, each rd_valid one cycle after accept, rd_bank_done after words 31 and 63, wr_ready reasserts the cycle after first drain.
REQ-041 Random wr_valid/rd_req streaming of 256 incrementing words -> output sequence identical, no bank_we and bank_re on the same bank in any cycle.
REQ-042 resetn pulsed low after 10 writes -> outputs cleared immediately; next rd_valid only after 32 new writes; first word read is first post-reset write.
